my_srl_fifo: RTL and testbench
==============================

MY_SRL_FIFO -- requirements
Module: my_srl_fifo

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the data width in bits (legal range 1..64).
REQ-002 The block SHALL have parameter DEPTH, fixed at 16 entries and not overridable, matching one SRL16-style shift chain per data bit.
REQ-003 The block SHALL have port CLK  input  1  single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port CLR_N  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port WR_EN  input  1  write request; shifts WR_DATA into the chain when accepted.
REQ-006 The block SHALL have port WR_DATA  input  WIDTH  write data.
REQ-007 The block SHALL have port RD_EN  input  1  read request; pops the oldest entry when accepted.
REQ-008 The block SHALL have port RD_DATA  output  WIDTH  oldest entry, first-word-fall-through.
REQ-009 The block SHALL have port EMPTY  output  1  high when COUNT==0.
REQ-010 The block SHALL have port FULL  output  1  high when COUNT==16.
REQ-011 The block SHALL have port COUNT  output  5  number of stored entries, 0..16.
REQ-012 The block SHALL have port OVF  output  1  sticky flag: a write was attempted while FULL.
REQ-013 The block SHALL have port UNF  output  1  sticky flag: a read was attempted while EMPTY.

Function
REQ-014 Storage SHALL be a 16-stage shift chain: on an accepted write, stage 0 takes WR_DATA and stage k takes stage k-1 for k=1..15.
REQ-015 Storage SHALL NOT be reset and SHALL have no clock-enable path other than an accepted write, so it maps onto SRL16E primitives.
REQ-016 The read address SHALL be COUNT-1, so RD_DATA = stage[COUNT-1] combinationally whenever EMPTY=0.
REQ-017 RD_DATA SHALL be driven to all-zeros while EMPTY=1.
REQ-018 A write SHALL be accepted when WR_EN=1 and FULL=0.
REQ-019 A read SHALL be accepted when RD_EN=1 and EMPTY=0.
REQ-020 Accepted write only: COUNT SHALL increment by 1 on the same edge.
REQ-021 Accepted read only: COUNT SHALL decrement by 1; the storage SHALL NOT shift.
REQ-022 Accepted write and accepted read on the same edge: the chain SHALL shift and COUNT SHALL stay unchanged; RD_DATA in the following cycle is the next-oldest entry.
REQ-023 When FULL=1, WR_EN=1 and RD_EN=1 on the same edge, the read SHALL be accepted and the write SHALL be rejected; the chain SHALL NOT shift, COUNT SHALL become 15 and OVF SHALL set.
REQ-024 When EMPTY=1, RD_EN=1 and WR_EN=1 on the same edge, the write SHALL be accepted and the read SHALL be rejected; COUNT SHALL become 1 and UNF SHALL set.
REQ-025 A rejected write SHALL leave the storage and COUNT unchanged and SHALL set OVF on that edge.
REQ-026 A rejected read SHALL leave COUNT unchanged and SHALL set UNF on that edge.
REQ-027 OVF and UNF SHALL hold at 1 until reset.
REQ-028 COUNT SHALL never exceed 16 or wrap below 0.
REQ-029 EMPTY, FULL, COUNT, OVF and UNF SHALL be registered or decoded directly from registered COUNT, with no combinational path from WR_EN or RD_EN.
REQ-030 Latency SHALL be as follows: data written on edge N is visible on RD_DATA after edge N if the FIFO was empty, and after the edge of the read that exposes it otherwise.

Reset
REQ-031 Asserting CLR_N=0 SHALL immediately force COUNT=0, EMPTY=1, FULL=0, OVF=0, UNF=0 and RD_DATA=0, with no clock edge required.
REQ-032 Storage contents SHALL be retained across reset but SHALL be unobservable until rewritten.
REQ-033 WR_EN and RD_EN SHALL be ignored on any edge where CLR_N=0.
REQ-034 Reset asserted mid-operation with traffic pending SHALL leave the block empty after deassertion; the first following write SHALL appear on RD_DATA.

Verification
REQ-035 The bench SHALL cover reset then idle: CLR_N low then high, no enables -> COUNT=0, EMPTY=1, FULL=0, RD_DATA=0x00, OVF=UNF=0.
REQ-036 The bench SHALL cover fill and drain: write 0x01..0x10 (16 writes) -> FULL=1, COUNT=16, RD_DATA=0x01; 16 reads -> RD_DATA sequence 0x01..0x10, then EMPTY=1.
REQ-037 The bench SHALL cover overflow: from full, WR_EN=1 with 0xAA -> COUNT stays 16, OVF=1; drain shows no 0xAA.
REQ-038 The bench SHALL cover underflow with simultaneous write: from empty, RD_EN=WR_EN=1 with 0x5C -> COUNT=1, UNF=1, RD_DATA=0x5C.
REQ-039 The bench SHALL cover simultaneous read and write at COUNT=3 (0x11,0x22,0x33), WR_DATA=0x44 -> COUNT=3, RD_DATA=0x22, subsequent reads 0x33,0x44.
REQ-040 The bench SHALL cover asynchronous reset mid-traffic: at COUNT=7, pulse CLR_N low between edges -> COUNT=0 and EMPTY=1 immediately; then write 0x77 -> RD_DATA=0x77, COUNT=1.

Source files
------------

// File: rtl/my_srl_fifo.sv
// First-word-fall-through FIFO built on a 16-stage shift chain per data bit.
// Writes always enter at stage 0; the oldest entry is read from stage COUNT-1.
module my_srl_fifo #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] WR_DATA,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] RD_DATA,
    output logic             EMPTY,
    output logic             FULL,
    output logic [4:0]       COUNT,
    output logic             OVF,
    output logic             UNF
);

    localparam int DEPTH = 16;

    logic [WIDTH-1:0] srl_q [DEPTH];
    logic [WIDTH-1:0] srl_d [DEPTH];
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             unf_q, unf_d;
    logic             empty, full;
    logic             wr_acc, rd_acc;
    logic [3:0]       rd_addr;

    assign empty   = (count_q == 5'd0);
    assign full    = (count_q == 5'd16);
    assign wr_acc  = CLR_N && WR_EN && !full;
    assign rd_acc  = CLR_N && RD_EN && !empty;
    // COUNT==16 wraps the 4-bit address to 15, the last stage.
    assign rd_addr = count_q[3:0] - 4'd1;

    always_comb begin
        srl_d = srl_q;
        if (wr_acc) begin
            srl_d[0] = WR_DATA;
            for (int k = 1; k < DEPTH; k++) begin
                srl_d[k] = srl_q[k-1];
            end
        end
    end

    // No reset and a single enable so the chain maps onto SRL16E cells.
    always_ff @(posedge CLK) begin
        srl_q <= srl_d;
    end

    always_comb begin
        count_d = count_q;
        unique case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + 5'd1;
            2'b01:   count_d = count_q - 5'd1;
            default: count_d = count_q;
        endcase
        ovf_d = ovf_q | (WR_EN & full);
        unf_d = unf_q | (RD_EN & empty);
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign RD_DATA = empty ? '0 : srl_q[rd_addr];
    assign EMPTY   = empty;
    assign FULL    = full;
    assign COUNT   = count_q;
    assign OVF     = ovf_q;
    assign UNF     = unf_q;

endmodule

// File: tb/tb_my_srl_fifo.sv
// Bench for my_srl_fifo: directed scenarios plus random traffic against a queue model;
// popped data is checked by a separate monitor through an expected queue.
module tb_my_srl_fifo;

    localparam int W = 8;

    logic         clk;
    logic         clr_n;
    logic         wr_en;
    logic [W-1:0] wr_data;
    logic         rd_en;
    logic [W-1:0] rd_data;
    logic         empty_o;
    logic         full_o;
    logic [4:0]   count_o;
    logic         ovf_o;
    logic         unf_o;

    int n_checks = 0;
    int n_pass   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] model_q[$];
    logic         model_ovf = 1'b0;
    logic         model_unf = 1'b0;

    my_srl_fifo #(.WIDTH(W)) dut (
        .CLK     (clk),
        .CLR_N   (clr_n),
        .WR_EN   (wr_en),
        .WR_DATA (wr_data),
        .RD_EN   (rd_en),
        .RD_DATA (rd_data),
        .EMPTY   (empty_o),
        .FULL    (full_o),
        .COUNT   (count_o),
        .OVF     (ovf_o),
        .UNF     (unf_o)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // Compare every observable output against the model.
    task automatic check_status(input string tag);
        logic [W-1:0] exp_rd;
        exp_rd = (model_q.size() != 0) ? model_q[0] : '0;
        chk({tag, ".count"}, 64'(count_o), 64'(model_q.size()));
        chk({tag, ".empty"}, 64'(empty_o), 64'(model_q.size() == 0));
        chk({tag, ".full"},  64'(full_o),  64'(model_q.size() == 16));
        chk({tag, ".ovf"},   64'(ovf_o),   64'(model_ovf));
        chk({tag, ".unf"},   64'(unf_o),   64'(model_unf));
        chk({tag, ".rd_data"}, 64'(rd_data), 64'(exp_rd));
    endtask

    // driver: called at posedge+1, drives one edge, returns at posedge+1 with enables low
    task automatic step(input logic wr, input logic [W-1:0] d, input logic rd, input string tag);
        bit m_full, m_empty;
        wr_en   = wr;
        wr_data = d;
        rd_en   = rd;
        m_full  = (model_q.size() == 16);
        m_empty = (model_q.size() == 0);
        if (wr && m_full)  model_ovf = 1'b1;
        if (rd && m_empty) model_unf = 1'b1;
        if (rd && !m_empty) begin
            exp_q.push_back(model_q[0]);
            void'(model_q.pop_front());
        end
        if (wr && !m_full) model_q.push_back(d);
        @(posedge clk);
        #1;
        wr_en = 1'b0;
        rd_en = 1'b0;
        check_status(tag);
    endtask

    // asynchronous reset pulse between edges; outputs must clear with no clock
    task automatic reset_pulse(input string tag);
        #2 clr_n = 1'b0;
        #1;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check_status(tag);
        #1 clr_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    // scoreboard monitor: mid-cycle, whenever a read will be accepted, RD_DATA is the popped word
    always @(negedge clk) begin
        if (clr_n && rd_en && !empty_o) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                $display("FAIL pop: got 0x%0h expected nothing at %0t", rd_data, $time);
            end else begin
                logic [W-1:0] e;
                e = exp_q.pop_front();
                if (rd_data === e) n_pass++;
                else $display("FAIL pop: got 0x%0h expected 0x%0h at %0t", rd_data, e, $time);
            end
        end
    end

    initial begin
        clr_n   = 1'b0;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check_status("reset_low");
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        check_status("reset_idle");

        // fill and drain with overflow and full read+write corner
        for (int i = 1; i <= 16; i++) step(1'b1, W'(i), 1'b0, "fill");
        step(1'b1, 8'hAA, 1'b0, "ovf");
        step(1'b1, 8'hBB, 1'b1, "full_rw");
        for (int i = 0; i < 15; i++) step(1'b0, '0, 1'b1, "drain");
        step(1'b0, '0, 1'b1, "unf");

        // underflow with simultaneous write
        reset_pulse("rst1");
        step(1'b1, 8'h5C, 1'b1, "empty_rw");
        step(1'b0, '0, 1'b1, "read_5c");

        // simultaneous read/write at COUNT=3
        step(1'b1, 8'h11, 1'b0, "w11");
        step(1'b1, 8'h22, 1'b0, "w22");
        step(1'b1, 8'h33, 1'b0, "w33");
        step(1'b1, 8'h44, 1'b1, "rw44");
        for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1, "read3");

        // reset mid traffic at COUNT=7, then enables held during reset are ignored
        for (int i = 0; i < 7; i++) step(1'b1, W'(8'h60 + i), 1'b0, "w7");
        reset_pulse("rst_mid");
        step(1'b1, 8'h77, 1'b0, "w77");
        clr_n = 1'b0;
        wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
        @(posedge clk);
        #1;
        wr_en = 1'b0; rd_en = 1'b0;
        model_q.delete();
        model_ovf = 1'b0;
        model_unf = 1'b0;
        check_status("held_rst");
        clr_n = 1'b1;
        @(posedge clk);
        #1;
        step(1'b1, 8'h3E, 1'b0, "after_rst");

        // random traffic, biased so the FIFO visits both full and empty
        for (int i = 0; i < 600; i++) begin
            int phase;
            phase = (i / 60) % 2;
            if (i % 149 == 148) reset_pulse("rnd_rst");
            step(1'b1 & ($urandom_range(0, 99) < (phase ? 30 : 70)),
                 W'($urandom),
                 1'b1 & ($urandom_range(0, 99) < (phase ? 70 : 30)),
                 "rnd");
        end

        repeat (2) @(posedge clk);
        #1;
        chk("exp_q_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
